cmd_responder: RTL and testbench
================================

# cmd_responder

Synthesizable target end of the host command protocol (nop / write reg / read reg / write mem / read mem) that the simulation harness drives by backdoor. It sits inside the design, accepts one command at a time over a valid/ready channel, and executes it against an internal register file and an external single-port synchronous RAM. Each command returns exactly one response with data and status, so the same command streams run on hardware as in simulation.

## Interface
- NUM_REGS, 4: number of 32-bit registers; valid reg ids are 0..NUM_REGS-1.
- MEM_DEPTH, 16: RAM words; valid addrs are 0..MEM_DEPTH-1.
- LANES, 1: number of 32-bit lanes per RAM word; valid masks are 0..LANES-1.
- clock  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  responder can accept.
- cmd_opcode  in  32  0 nop, 1 write reg, 2 read reg, 3 write mem, 4 read mem.
- cmd_id  in  32  register index for opcodes 1/2; must be 0 for 3/4.
- cmd_mask  in  32  lane select for opcodes 3/4.
- cmd_addr  in  32  RAM word address for opcodes 3/4.
- cmd_data  in  32  write value for opcodes 1/3.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host takes response.
- rsp_data  out  32  response data.
- rsp_status  out  2  0 ok, 1 bad opcode, 2 bad id, 3 mask/addr out of range.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write when mem_en.
- mem_addr  out  $clog2(MEM_DEPTH)  RAM word address.
- mem_wdata  out  32*LANES  full-word write data.
- mem_rdata  in  32*LANES  read data, valid the cycle after a mem_en read.
- reg_q  out  32*NUM_REGS  live register contents, reg i at bits [32*i+:32].

## Operation
- FSM states: IDLE, RD, WAIT, WR, RESP. cmd_ready=1 only in IDLE. One command in flight.
- Accept when cmd_valid && cmd_ready. All cmd_* fields are latched then and are ignored afterwards.
- Decode at accept, with checks in priority order: opcode>4 -> status 1. Opcodes 1/2 with id>=NUM_REGS, or opcodes 3/4 with id!=0 -> status 2. Opcodes 3/4 with mask>=LANES or addr>=MEM_DEPTH -> status 3.
- Error commands go IDLE->RESP with rsp_data=0. They have no side effects and never assert mem_en.
- nop: IDLE->RESP, rsp_data=32'hdeadbeef, status 0.
- write reg: reg[id]<=data on the accept edge. IDLE->RESP, rsp_data=data.
- read reg: IDLE->RESP, rsp_data=reg[id] as of the accept cycle.
- read mem: IDLE->RD (mem_en=1, mem_we=0, mem_addr=addr) ->WAIT (capture mem_rdata) ->RESP. rsp_data=lane[mask].
- write mem (read-modify-write): the IDLE->RD->WAIT steps match read mem. In WAIT, merge data into lane[mask] and keep the other lanes. Then WR (mem_en=1, mem_we=1, mem_wdata=merged) ->RESP, rsp_data=data.
- RESP: rsp_valid=1 and rsp_data/rsp_status are held stable until rsp_ready. On the handshake edge go to IDLE.
- mem_en/mem_we are asserted only in RD and WR.

## Timing
- Accept edge = cycle T.
- nop, reg ops and errors: rsp_valid from T+1.
- read mem: mem_en at T+1, rdata captured at T+2, rsp_valid from T+3.
- write mem: mem_en read at T+1, write at T+3, rsp_valid from T+4. RAM is updated by the end of T+3.
- If the response handshake occurs in cycle R, cmd_ready=1 in R+1. Minimum command spacing is 2 cycles for reg ops, 4 for mem reads, 5 for mem writes.
- Reset values: state IDLE, all reg 0, rsp_valid 0, rsp_data 0, rsp_status 0, mem_en 0, mem_we 0. cmd_ready=0 while reset is high and 1 in the first cycle after.
- Reset mid-operation: the command is abandoned and its pending response dropped. No mem write is issued in or after the reset cycle. A reg write whose accept edge coincides with reset is not performed.
- rsp_ready held high in RESP gives a single-cycle response. rsp_ready asserted outside RESP is ignored.
- cmd_valid outside IDLE is not accepted. The host must hold it.

## Test plan
- Reset, then nop -> rsp at T+1: data 0xdeadbeef, status 0. reg_q all 0.
- Write reg id 2 data 0x12345678, then read reg id 2 -> responses 0x12345678/ok, reg_q[95:64]=0x12345678. Read id 4 (NUM_REGS=4) -> status 2, data 0.
- LANES=2: preload RAM addr 5 = {0xAAAA0000,0x5555FFFF}. Write mem addr 5 mask 1 data 0xCAFEF00D -> mem_wdata={0xCAFEF00D,0x5555FFFF} at T+3, rsp at T+4. Read mem addr 5 mask 0 -> 0x5555FFFF at T+3.
- Errors: opcode 7 -> status 1; mem op id 1 -> status 2; addr 16 -> status 3; mask 2 -> status 3. None of these assert mem_en, and reg_q is unchanged.
- Backpressure: rsp_ready low for 5 cycles after a read -> rsp_valid/data/status stable; cmd_ready low throughout and high the cycle after the handshake.
- Assert reset during WAIT of a write mem -> no mem_we pulse, rsp_valid 0, RAM word unchanged, next command accepted normally.

Source files
------------

// File: rtl/cmd_responder.sv
// cmd_responder: executes one host command at a time. The commands are
// nop, write reg, read reg, write mem and read mem. They run against an
// internal register file and an external single-port synchronous RAM.
// Every accepted command produces exactly one response (data + status).
//
// Handshake rules (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. The producer holds valid and
// its payload stable until that edge. cmd_ready is high only in IDLE.
// rsp_valid is high only in RESP, and the response payload is held there
// until rsp_ready is seen.
module cmd_responder #(
  parameter int NUM_REGS  = 4,
  parameter int MEM_DEPTH = 16,
  parameter int LANES     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               cmd_opcode,
  input  logic [31:0]               cmd_id,
  input  logic [31:0]               cmd_mask,
  input  logic [31:0]               cmd_addr,
  input  logic [31:0]               cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic [1:0]                rsp_status,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [32*LANES-1:0]       mem_wdata,
  input  logic [32*LANES-1:0]       mem_rdata,
  output logic [32*NUM_REGS-1:0]    reg_q,
  output logic [2:0]                dbg_state
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int MW = 32 * LANES;
  localparam int RW = 32 * NUM_REGS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_BAD_OP = 2'd1;
  localparam logic [1:0] ST_BAD_ID = 2'd2;
  localparam logic [1:0] ST_RANGE  = 2'd3;

  state_t          state_q, state_d;
  logic [RW-1:0]   regs_q, regs_d;
  logic            is_wr_q, is_wr_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [MW-1:0]   word_q, word_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_status_q, rsp_status_d;

  // decode signals
  logic            is_reg_op;
  logic            is_mem_op;
  logic            bad_op;
  logic            bad_id;
  logic            bad_range;
  logic [1:0]      dec_status;
  logic [31:0]     reg_base;
  logic [31:0]     lane_base;

  // Command decode: status checks in priority order, plus bit offsets of
  // the addressed register and of the latched RAM lane.
  always_comb begin
    is_reg_op  = (cmd_opcode == 32'd1) || (cmd_opcode == 32'd2);
    is_mem_op  = (cmd_opcode == 32'd3) || (cmd_opcode == 32'd4);
    bad_op     = (cmd_opcode > 32'd4);
    bad_id     = (is_reg_op && (cmd_id >= 32'(NUM_REGS))) ||
                 (is_mem_op && (cmd_id != 32'd0));
    bad_range  = is_mem_op && ((cmd_mask >= 32'(LANES)) ||
                               (cmd_addr >= 32'(MEM_DEPTH)));
    if (bad_op) begin
      dec_status = ST_BAD_OP;
    end else if (bad_id) begin
      dec_status = ST_BAD_ID;
    end else if (bad_range) begin
      dec_status = ST_RANGE;
    end else begin
      dec_status = ST_OK;
    end
    reg_base  = 32'(cmd_id[IW-1:0]) << 5;
    lane_base = 32'(lane_q) << 5;
  end

  // Next-state logic. A command is accepted and its side effects start in
  // IDLE. Memory commands then walk RD -> WAIT (-> WR) -> RESP.
  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    is_wr_d      = is_wr_q;
    lane_d       = lane_q;
    addr_d       = addr_q;
    data_d       = data_q;
    word_d       = word_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rsp_status_d = dec_status;
          rsp_data_d   = 32'd0;
          is_wr_d      = (cmd_opcode == 32'd3);
          lane_d       = cmd_mask[LW-1:0];
          addr_d       = cmd_addr[AW-1:0];
          data_d       = cmd_data;
          state_d      = S_RESP;
          if (dec_status == ST_OK) begin
            case (cmd_opcode[2:0])
              3'd0: rsp_data_d = 32'hdeadbeef;
              3'd1: begin
                regs_d[reg_base +: 32] = cmd_data;
                rsp_data_d             = cmd_data;
              end
              3'd2:    rsp_data_d = regs_q[reg_base +: 32];
              default: state_d    = S_RD;
            endcase
          end
        end
      end
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (is_wr_q) begin
          // Merge the new data into one lane and keep the other lanes as read.
          word_d                  = mem_rdata;
          word_d[lane_base +: 32] = data_q;
          rsp_data_d              = data_q;
          state_d                 = S_WR;
        end else begin
          rsp_data_d = mem_rdata[lane_base +: 32];
          state_d    = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any command in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      regs_q       <= '0;
      is_wr_q      <= 1'b0;
      lane_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      word_q       <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      is_wr_q      <= is_wr_d;
      lane_q       <= lane_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      word_q       <= word_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Handshake and RAM strobes follow the state. They are gated by reset, so
  // nothing is offered or written during the reset cycle.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !reset;
    rsp_valid = (state_q == S_RESP) && !reset;
    mem_en    = ((state_q == S_RD) || (state_q == S_WR)) && !reset;
    mem_we    = (state_q == S_WR) && !reset;
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign reg_q      = regs_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Bench for cmd_responder. A driver issues directed commands and pushes the
// expected {status, data} into a queue. A monitor pops and compares at every
// response handshake. A small RAM model serves the memory port.
module tb_cmd_responder;

  localparam int NR = 4;
  localparam int MD = 16;
  localparam int LN = 2;

  localparam logic [63:0] P5 = {32'hAAAA0000, 32'h5555FFFF};
  localparam logic [63:0] P7 = {32'h01234567, 32'h89ABCDEF};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_opcode = '0;
  logic [31:0]   cmd_id = '0;
  logic [31:0]   cmd_mask = '0;
  logic [31:0]   cmd_addr = '0;
  logic [31:0]   cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_status;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic [127:0]  reg_q;
  logic [2:0]    dbg_state;

  cmd_responder #(.NUM_REGS(NR), .MEM_DEPTH(MD), .LANES(LN)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_id(cmd_id), .cmd_mask(cmd_mask),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_q(reg_q), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end, required $finish");
    $fatal(1, "watchdog");
  end

  // RAM model: single port, synchronous read one cycle after mem_en
  logic [63:0] ram [MD];
  logic        preload = 1'b0;
  always @(posedge clock) begin
    if (preload) begin
      ram[5] <= P5;
      ram[7] <= P7;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // counters and scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // memory strobe monitor
  int          en_cnt = 0;
  int          we_cnt = 0;
  int          we_cyc = -1;
  logic [63:0] last_wdata = '0;
  initial forever begin
    @(negedge clock);
    if (mem_en) en_cnt++;
    if (mem_en && mem_we) begin
      we_cnt++;
      we_cyc     = cyc;
      last_wdata = mem_wdata;
    end
  end

  // response monitor: pop and compare on every handshake
  initial forever begin
    logic [33:0] e;
    @(negedge clock);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got {%0d,0x%0h} required no response", rsp_status, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_status_data", {30'd0, rsp_status, rsp_data}, {30'd0, e});
      end
    end
  end

  int acc_cyc = 0;

  // driver: issue a command and measure cycles from accept to rsp_valid
  task automatic do_cmd(input string name, input logic [31:0] op, input logic [31:0] id,
                        input logic [31:0] mask, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] est,
                        input logic [31:0] edat, input int elat);
    int lat;
    int k;
    exp_q.push_back({est, edat});
    @(negedge clock);
    cmd_opcode = op; cmd_id = id; cmd_mask = mask; cmd_addr = addr; cmd_data = data;
    cmd_valid  = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!cmd_ready) begin
      check({name, "_accept_timeout"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) break;
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
  endtask

  // called at the negedge where the response handshake is pending
  task automatic finish_rsp(input string name);
    @(negedge clock);
    check({name, "_ready_after"}, {62'd0, cmd_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
  endtask

  initial begin
    int snap_en;
    int snap_we;

    // reset
    preload = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset_rsp_valid_mem_en", {62'd0, rsp_valid, mem_en}, 64'd0);
    preload = 1'b0;
    reset   = 1'b0;
    @(negedge clock);
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_reset_reg_q_zero", 64'(reg_q == 128'd0), 64'd1);
    check("post_reset_rsp", {30'd0, rsp_status, rsp_data}, 64'd0);
    check("post_reset_state", 64'(dbg_state), 64'd0);

    // nop and register operations
    do_cmd("nop", 0, 0, 0, 0, 0, 2'd0, 32'hdeadbeef, 1);
    finish_rsp("nop");
    do_cmd("wr_reg2", 1, 2, 0, 0, 32'h12345678, 2'd0, 32'h12345678, 1);
    finish_rsp("wr_reg2");
    check("reg_q_word2", reg_q[95:64], 64'h12345678);
    do_cmd("wr_reg0", 1, 0, 0, 0, 32'hA5A50001, 2'd0, 32'hA5A50001, 1);
    finish_rsp("wr_reg0");
    do_cmd("rd_reg2", 2, 2, 0, 0, 0, 2'd0, 32'h12345678, 1);
    finish_rsp("rd_reg2");
    do_cmd("rd_reg0", 2, 0, 0, 0, 0, 2'd0, 32'hA5A50001, 1);
    finish_rsp("rd_reg0");
    do_cmd("rd_reg4", 2, 4, 0, 0, 0, 2'd2, 32'd0, 1);
    finish_rsp("rd_reg4");

    // memory read-modify-write and reads
    snap_en = en_cnt;
    snap_we = we_cnt;
    do_cmd("wr_mem5", 3, 0, 1, 5, 32'hCAFEF00D, 2'd0, 32'hCAFEF00D, 4);
    check("wr_mem5_wdata", last_wdata, {32'hCAFEF00D, 32'h5555FFFF});
    check("wr_mem5_we_cycle", 64'(we_cyc - acc_cyc), 64'd2);
    finish_rsp("wr_mem5");
    check("wr_mem5_strobes", 64'({en_cnt - snap_en, we_cnt - snap_we}), 64'({32'd2, 32'd1}));
    check("wr_mem5_ram", ram[5], {32'hCAFEF00D, 32'h5555FFFF});
    snap_en = en_cnt;
    snap_we = we_cnt;
    do_cmd("rd_mem5_l0", 4, 0, 0, 5, 0, 2'd0, 32'h5555FFFF, 3);
    finish_rsp("rd_mem5_l0");
    check("rd_mem5_strobes", 64'({en_cnt - snap_en, we_cnt - snap_we}), 64'({32'd1, 32'd0}));
    do_cmd("rd_mem5_l1", 4, 0, 1, 5, 0, 2'd0, 32'hCAFEF00D, 3);
    finish_rsp("rd_mem5_l1");

    // error commands: no RAM access, no register change
    snap_en = en_cnt;
    do_cmd("err_op7", 7, 9, 5, 99, 32'h1, 2'd1, 32'd0, 1);
    finish_rsp("err_op7");
    do_cmd("err_mem_id1", 3, 1, 0, 5, 32'h2, 2'd2, 32'd0, 1);
    finish_rsp("err_mem_id1");
    do_cmd("err_addr16", 4, 0, 0, 16, 0, 2'd3, 32'd0, 1);
    finish_rsp("err_addr16");
    do_cmd("err_mask2", 3, 0, 2, 5, 32'h3, 2'd3, 32'd0, 1);
    finish_rsp("err_mask2");
    do_cmd("err_wr_reg5", 1, 5, 0, 0, 32'hFFFFFFFF, 2'd2, 32'd0, 1);
    finish_rsp("err_wr_reg5");
    check("err_no_mem_en", 64'(en_cnt - snap_en), 64'd0);
    check("err_reg_q_lo", reg_q[63:0], {32'd0, 32'hA5A50001});
    check("err_reg_q_hi", reg_q[127:64], {32'd0, 32'h12345678});
    check("err_ram5", ram[5], {32'hCAFEF00D, 32'h5555FFFF});

    // backpressure on a read
    rsp_ready = 1'b0;
    do_cmd("bp_rd_reg2", 2, 2, 0, 0, 0, 2'd0, 32'h12345678, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_hold", {29'd0, rsp_valid, cmd_ready, rsp_status, rsp_data},
            {29'd0, 1'b1, 1'b0, 2'd0, 32'h12345678});
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_ready_in_handshake", 64'(cmd_ready), 64'd0);
    @(negedge clock);
    check("bp_ready_after", {62'd0, cmd_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});

    // reset during WAIT of a write mem
    snap_we = we_cnt;
    @(negedge clock);
    cmd_opcode = 3; cmd_id = 0; cmd_mask = 0; cmd_addr = 7; cmd_data = 32'hFFFFFFFF;
    cmd_valid  = 1'b1;
    check("rst_wr_ready", 64'(cmd_ready), 64'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    check("rst_in_wait", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    #1;
    check("rst_gates_ready_mem", {62'd0, cmd_ready, mem_en}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_no_we", 64'(we_cnt - snap_we), 64'd0);
    check("rst_no_rsp", 64'(rsp_valid), 64'd0);
    check("rst_ram7", ram[7], P7);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    do_cmd("rst_rd_mem7_l0", 4, 0, 0, 7, 0, 2'd0, 32'h89ABCDEF, 3);
    finish_rsp("rst_rd_mem7_l0");
    do_cmd("rst_rd_mem7_l1", 4, 0, 1, 7, 0, 2'd0, 32'h01234567, 3);
    finish_rsp("rst_rd_mem7_l1");
    do_cmd("rst_rd_reg2", 2, 2, 0, 0, 0, 2'd0, 32'd0, 1);
    finish_rsp("rst_rd_reg2");

    // final report
    repeat (3) @(negedge clock);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
